bcd_display_ctrl: RTL and testbench
===================================

// Module: bcd_display_ctrl
// PURPOSE
//  Sequential display controller for the FPGA 4-digit seven-segment readout.
//  Accepts a 13-bit binary value through a valid/ready handshake and converts it to
//  4 BCD digits with an iterative shift-add-3 engine, one bit per cycle.
//  Holds the result and time-multiplexes it onto the anodes and segments.
//  Sits between the core's debug/output register and the board display pins.
// PARAMETERS
//  REFRESH_DIV    100000  clk cycles each digit is lit (must be >= 1)
//  BLANK_LEADING  0       1 = blank leading-zero digits 3..1; digit 0 always lit
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst        in   1   synchronous reset, active-high
//  val_valid  in   1   val_data is presented
//  val_data   in   13  binary value to display, 0..8191
//  val_ready  out  1   block can accept; high only in IDLE
//  conv_done  out  1   one-cycle pulse when digits is updated
//  digits     out  16  {thousands,hundreds,tens,ones} BCD of last completed value
//  anode      out  4   active-low digit enables, bit i = digit i (0 = ones)
//  seg        out  7   active-low cathodes {g,f,e,d,c,b,a}
// BEHAVIOUR
//  Reset: state=IDLE, digits=0, conv_done=0, refresh cnt=0, sel=0,
//   anode=4'b1110, seg=7'b1000000 ("0"); val_ready=1. Applies in any state.
//  FSM IDLE -> CONV -> UPDATE -> IDLE.
//  IDLE: val_ready=1. Edge with val_valid=1: capture val_data into shift reg,
//   clear 16-bit scratch, bit cnt=12, go CONV. val_valid=0: stay.
//  CONV: each edge, every scratch nibble >=5 gets +3 (4-bit, no carry out), then
//   {scratch,shift} shifts left 1 (MSB of val_data first). After iteration with
//   cnt=0 (13th), go UPDATE; else cnt-1.
//  UPDATE: digits<=scratch, conv_done=1 for the following cycle, go IDLE.
//  Latency: accept at edge N; digits valid and conv_done high after edge N+14;
//   val_ready low from N to N+14; max 1 accept per 15 cycles.
//  val_valid while val_ready=0 is ignored (no queue); held val_valid is taken
//   on the first IDLE edge.
//  digits changes only in UPDATE; the display reads only digits, never scratch.
//  Refresh: cnt counts 0..REFRESH_DIV-1 free-running; at wrap sel increments
//   mod 4 (0,1,2,3,0). Unaffected by conversions.
//  anode = ~(4'b0001<<sel); seg = decode(digits nibble sel), both combinational
//   from registers.
//  Blanking (BLANK_LEADING=1): digit sel>0 whose nibble and all higher nibbles
//   are 0 -> anode=4'b1111, seg=7'h7F.
//  Decoder: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//   6=0000010 7=1111000 8=0000000 9=0010000; >9 (unreachable) -> 7'h7F.
//  rst mid-CONV/UPDATE aborts; digits=0, no conv_done pulse.
// TESTING
//  1 rst 2 cycles -> anode 1110, seg 1000000, digits 0, val_ready 1, conv_done 0.
//  2 val_data=1234 accepted at edge N -> val_ready low N..N+14, conv_done pulses
//    after N+14, digits=16'h1234.
//  3 Values 0, 9, 8191 back-to-back (valid held) -> digits 0000, 0009, 8191;
//    accepts 15 cycles apart.
//  4 After accepting 1234, present 5678 for 3 busy cycles then drop -> ignored;
//    digits=1234, one conv_done only.
//  5 REFRESH_DIV=4, digits 1234 -> anode 1110,1101,1011,0111 for 4 cycles each;
//    seg 0011001,0110000,0100100,1111001.
//  6 BLANK_LEADING=1, value 42 -> digits 3,2 show anode 1111; rst mid-CONV of 77
//    -> digits 0, no conv_done pulse, val_ready=1 next cycle.

Source files
------------

// File: rtl/bcd_display_ctrl.sv
// bcd_display_ctrl: serial shift-add-3 binary-to-BCD converter driving a multiplexed 4-digit seven-segment display
module bcd_display_ctrl #(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        val_valid,
  input  logic [12:0] val_data,
  output logic        val_ready,
  output logic        conv_done,
  output logic [15:0] digits,
  output logic [3:0]  anode,
  output logic [6:0]  seg
);
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;
  state_t          r_state;
  logic [12:0]     r_shift;
  logic [15:0]     r_scratch;
  logic [15:0]     w_adj;
  logic [3:0]      r_cnt;
  logic [3:0]      w_nib;
  logic [CW-1:0]   r_ref;
  logic [1:0]      r_sel;
  logic            w_wrap;
  logic            w_blank;
  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign w_adj[4*i +: 4] = r_scratch[4*i +: 4] >= 4'd5 ? r_scratch[4*i +: 4] + 4'd3 : r_scratch[4*i +: 4];
  end
  assign w_wrap = r_ref == CW'(REFRESH_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      digits    <= '0;
      conv_done <= 1'b0;
      r_ref     <= '0;
      r_sel     <= '0;
    end else begin
      conv_done <= 1'b0;
      r_ref     <= w_wrap ? '0 : r_ref + 1'b1;
      r_sel     <= w_wrap ? r_sel + 2'd1 : r_sel;
      case (r_state)
        IDLE: if (val_valid) begin
          r_shift   <= val_data;
          r_scratch <= '0;
          r_cnt     <= 4'd12;
          r_state   <= CONV;
        end
        CONV: begin
          {r_scratch, r_shift} <= {w_adj, r_shift} << 1;
          r_cnt   <= r_cnt - 4'd1;
          r_state <= r_cnt == 4'd0 ? UPDATE : CONV;
        end
        UPDATE: begin
          digits    <= r_scratch;
          conv_done <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign val_ready = r_state == IDLE;
  assign w_nib     = digits[4*r_sel +: 4];
  assign w_blank   = BLANK_LEADING && r_sel != 2'd0 && (digits >> {r_sel, 2'b00}) == 16'd0;
  assign anode     = w_blank ? 4'b1111 : ~(4'b0001 << r_sel);
  always_comb begin
    seg = 7'h7F;
    if (!w_blank)
      case (w_nib)
        4'd0: seg = 7'b1000000;
        4'd1: seg = 7'b1111001;
        4'd2: seg = 7'b0100100;
        4'd3: seg = 7'b0110000;
        4'd4: seg = 7'b0011001;
        4'd5: seg = 7'b0010010;
        4'd6: seg = 7'b0000010;
        4'd7: seg = 7'b1111000;
        4'd8: seg = 7'b0000000;
        4'd9: seg = 7'b0010000;
        default: seg = 7'h7F;
      endcase
  end
endmodule

// File: tb/tb_bcd_display_ctrl.sv
// tb_bcd_display_ctrl: scoreboard bench for two display controller configurations
module tb_bcd_display_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        val_valid = 1'b0;
  logic [12:0] val_data = '0;
  logic        r0, c0, r1, c1;
  logic [15:0] d0, d1;
  logic [3:0]  a0, a1;
  logic [6:0]  s0, s1;
  always #5 clk = ~clk;
  bcd_display_ctrl #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut0 (
    .clk(clk), .rst(rst), .val_valid(val_valid), .val_data(val_data),
    .val_ready(r0), .conv_done(c0), .digits(d0), .anode(a0), .seg(s0));
  bcd_display_ctrl #(.REFRESH_DIV(3), .BLANK_LEADING(1'b1)) dut1 (
    .clk(clk), .rst(rst), .val_valid(val_valid), .val_data(val_data),
    .val_ready(r1), .conv_done(c1), .digits(d1), .anode(a1), .seg(s1));
  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;
  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          k = 0;
  int          busy_end = 0;
  bit          started = 1'b0;
  logic [15:0] mdig = '0;
  logic [6:0]  seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  function automatic logic [10:0] disp(logic [15:0] d, int sel, bit blank);
    logic [3:0] an;
    if (blank && sel > 0 && (d >> (4 * sel)) == 16'd0) return {4'hF, 7'h7F};
    an = 4'b0001 << sel;
    return {~an, seg_tab[d[4*sel +: 4]]};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      if (sb.size() > 0 && sb[0].c == cyc) begin
        e = sb.pop_front();
        chk("conv_done", {c0, c1}, 2'b11);
        mdig = e.d;
      end else
        chk("conv_done_quiet", {c0, c1}, 2'b00);
      chk("digits", d0, mdig);
      chk("digits_b", d1, mdig);
      chk("val_ready", {r0, r1}, {2{cyc >= busy_end}});
      chk("display", {a0, s0}, disp(mdig, (k / 4) % 4, 1'b0));
      chk("display_b", {a1, s1}, disp(mdig, (k / 3) % 4, 1'b1));
    end
    if (rst) begin
      started = 1'b1;
      k = 0;
      mdig = '0;
      sb.delete();
      busy_end = 0;
    end else begin
      k++;
      if (started && val_valid && cyc >= busy_end) begin
        sb.push_back('{to_bcd(int'(val_data)), cyc + 15});
        busy_end = cyc + 15;
      end
    end
    cyc++;
  end
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(int v);
    int n = 0;
    val_valid = 1'b1;
    val_data = 13'(v);
    forever begin
      @(negedge clk);
      if (r0) break;
      if (++n > 100) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout value %0d: got no val_ready expected val_ready=1", v);
        break;
      end
    end
    step(1);
  endtask
  initial begin
    step(2);
    rst = 1'b0;
    step(3);
    send(1234);
    val_valid = 1'b0;
    step(20);
    send(0);
    send(9);
    send(8191);
    val_valid = 1'b0;
    step(20);
    send(1234);
    val_data = 13'd5678;
    step(3);
    val_valid = 1'b0;
    step(20);
    step(40);
    send(42);
    val_valid = 1'b0;
    step(40);
    send(77);
    val_valid = 1'b0;
    step(5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(5);
    repeat (25) begin
      send(int'($urandom_range(0, 8191)));
      val_valid = 1'($urandom_range(0, 1));
      step(int'($urandom_range(0, 20)));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end
    end
    val_valid = 1'b0;
    step(20);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
